// File: rtl/spi_bus_arbiter_pkg.sv
// Shared definitions for the two-master SPI bus arbiter: FSM encoding,
// master indices and the levels the shared bus rests at when nobody owns it.
package spi_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

  localparam logic M_FLASH = 1'b0;
  localparam logic M_RAM   = 1'b1;

  localparam logic SPI_CLK_IDLE  = 1'b0;
  localparam logic SPI_MOSI_IDLE = 1'b0;
  localparam logic SPI_CS_IDLE   = 1'b1;
  localparam logic SPI_MISO_IDLE = 1'b0;

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_if.sv
// Bundle of request/grant handshake, per-master SPI pins and the shared bus.
// The arbiter connects through slave; the masters/bus side through master.
interface spi_bus_arbiter_if;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       m0_clk, m0_mosi, m0_cs_n, m0_miso;
  logic       m1_clk, m1_mosi, m1_cs_n, m1_miso;
  logic       spi_clk, spi_mosi, spi_miso;
  logic       spi_cs0_n, spi_cs1_n;

  modport slave (
    input  req, m0_clk, m0_mosi, m0_cs_n, m1_clk, m1_mosi, m1_cs_n, spi_miso,
    output gnt, m0_miso, m1_miso, spi_clk, spi_mosi, spi_cs0_n, spi_cs1_n
  );

  modport master (
    output req, m0_clk, m0_mosi, m0_cs_n, m1_clk, m1_mosi, m1_cs_n, spi_miso,
    input  gnt, m0_miso, m1_miso, spi_clk, spi_mosi, spi_cs0_n, spi_cs1_n
  );
endinterface

// File: rtl/spi_rr_pick.sv
// Combinational two-way winner select; on a tie either alternates away from
// the previous owner or always favours the flash master.
module spi_rr_pick
  import spi_bus_arbiter_pkg::*;
#(
  parameter int unsigned ROUND_ROBIN = 1
) (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = M_FLASH;
    case (req)
      2'b01:   winner = M_FLASH;
      2'b10:   winner = M_RAM;
      2'b11:   winner = (ROUND_ROBIN != 0) ? ~last_owner : M_FLASH;
      default: winner = M_FLASH;
    endcase
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI bus between the flash reader and the RAM controller with a
// registered req/gnt handshake, an enforced idle gap and an optional hold timeout.
module spi_bus_arbiter
  import spi_bus_arbiter_pkg::*;
#(
  parameter int unsigned ROUND_ROBIN = 1,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned TIMEOUT     = 0
) (
  input  logic                clk,
  input  logic                resetn,
  spi_bus_arbiter_if.slave    bus,
  output logic                busy,
  output logic                err
);

  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  arb_state_t  state, state_nxt;
  logic [1:0]  gnt_q, gnt_nxt;
  logic        owner, owner_nxt;
  logic        last_owner, last_owner_nxt;
  logic [15:0] hold_cnt, hold_cnt_nxt;
  logic [3:0]  gap_cnt, gap_cnt_nxt;
  logic        err_q, err_nxt;

  logic        pick_valid, pick_winner;
  logic        owner_req, owner_cs_n, timeout_hit;

  spi_rr_pick #(.ROUND_ROBIN(ROUND_ROBIN)) u_pick (
    .req        (bus.req),
    .last_owner (last_owner),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  assign owner_req   = owner ? bus.req[1] : bus.req[0];
  assign owner_cs_n  = owner ? bus.m1_cs_n : bus.m0_cs_n;
  assign timeout_hit = (TIMEOUT != 0) && (hold_cnt >= 16'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      gnt_q      <= '0;
      owner      <= M_FLASH;
      last_owner <= M_RAM;
      hold_cnt   <= '0;
      gap_cnt    <= '0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      gnt_q      <= gnt_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      hold_cnt   <= hold_cnt_nxt;
      gap_cnt    <= gap_cnt_nxt;
      err_q      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    gnt_nxt        = gnt_q;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    hold_cnt_nxt   = hold_cnt;
    gap_cnt_nxt    = gap_cnt;
    err_nxt        = err_q;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_nxt    = ST_GRANT;
          gnt_nxt      = onehot(pick_winner);
          owner_nxt    = pick_winner;
          hold_cnt_nxt = '0;
        end
      end
      ST_GRANT: begin
        hold_cnt_nxt = (hold_cnt == '1) ? hold_cnt : hold_cnt + 16'd1;
        // Timeout revokes exactly like a release; a release with cs_n still
        // asserted is also flagged since the slave saw a truncated frame.
        if (!owner_req || timeout_hit) begin
          state_nxt      = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
          gap_cnt_nxt    = GAP_LOAD;
          gnt_nxt        = '0;
          last_owner_nxt = owner;
          if (timeout_hit || !owner_cs_n) err_nxt = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) state_nxt = ST_IDLE;
        else               gap_cnt_nxt = gap_cnt - 4'd1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Mux select is the registered owner gated by state, so the bus only moves
  // on clock edges and rests at idle levels outside GRANT.
  always_comb begin
    bus.spi_clk   = SPI_CLK_IDLE;
    bus.spi_mosi  = SPI_MOSI_IDLE;
    bus.spi_cs0_n = SPI_CS_IDLE;
    bus.spi_cs1_n = SPI_CS_IDLE;
    bus.m0_miso   = SPI_MISO_IDLE;
    bus.m1_miso   = SPI_MISO_IDLE;
    if (state == ST_GRANT) begin
      if (owner == M_RAM) begin
        bus.spi_clk   = bus.m1_clk;
        bus.spi_mosi  = bus.m1_mosi;
        bus.spi_cs1_n = bus.m1_cs_n;
        bus.m1_miso   = bus.spi_miso;
      end else begin
        bus.spi_clk   = bus.m0_clk;
        bus.spi_mosi  = bus.m0_mosi;
        bus.spi_cs0_n = bus.m0_cs_n;
        bus.m0_miso   = bus.spi_miso;
      end
    end
  end

  assign bus.gnt = gnt_q;
  assign busy    = (state != ST_IDLE);
  assign err     = err_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Drives two arbiter configurations with identical stimulus and compares every
// cycle against a timestamp-based model of ownership, gaps and timeouts.
module tb_spi_bus_arbiter;

  logic clk = 1'b0;
  logic resetn;
  logic busy_a, err_a, busy_b, err_b;

  always #5 clk = ~clk;

  spi_bus_arbiter_if ifa();
  spi_bus_arbiter_if ifb();

  spi_bus_arbiter #(.ROUND_ROBIN(1), .GAP_CYCLES(2), .TIMEOUT(0)) dut_a (
    .clk(clk), .resetn(resetn), .bus(ifa.slave), .busy(busy_a), .err(err_a)
  );

  spi_bus_arbiter #(.ROUND_ROBIN(0), .GAP_CYCLES(3), .TIMEOUT(16)) dut_b (
    .clk(clk), .resetn(resetn), .bus(ifb.slave), .busy(busy_b), .err(err_b)
  );

  int cfg_rr  [2] = '{1, 0};
  int cfg_gap [2] = '{2, 3};
  int cfg_to  [2] = '{0, 16};

  // Model: owner (-1 = none), first cycle of the grant, first cycle requests
  // may be sampled again, last owner and sticky error.
  int m_owner [2];
  int m_start [2];
  int m_free  [2];
  int m_last  [2];
  bit m_err   [2];
  int cyc = 0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int pick(input int d, input logic [1:0] r);
    if (r == 2'b01) return 0;
    if (r == 2'b10) return 1;
    if (cfg_rr[d] != 0) return (m_last[d] == 0) ? 1 : 0;
    return 0;
  endfunction

  task automatic model_step(input int d, input logic [1:0] r, input logic [1:0] csn, input logic rst);
    int hold;
    bit rel, to;
    if (!rst) begin
      m_owner[d] = -1; m_last[d] = 1; m_err[d] = 0; m_free[d] = cyc + 1;
    end else if (m_owner[d] >= 0) begin
      hold = cyc - m_start[d];
      rel  = (r[m_owner[d]] == 1'b0);
      to   = (cfg_to[d] > 0) && (hold >= cfg_to[d]);
      if (rel || to) begin
        if (to || csn[m_owner[d]] == 1'b0) m_err[d] = 1;
        m_last[d]  = m_owner[d];
        m_owner[d] = -1;
        m_free[d]  = cyc + cfg_gap[d] + 1;
      end
    end else if (cyc >= m_free[d] && r != 2'b00) begin
      m_owner[d] = pick(d, r);
      m_start[d] = cyc + 1;
    end
  endtask

  task automatic cycle(input logic [1:0] r, input logic [1:0] csn, input logic rst, input bit chk);
    logic c0, c1, o0, o1, mi;
    logic [1:0]  eg;
    logic [5:0]  eb, ob;
    logic [1:0]  og, ost;
    string dn;
    c0 = 1'($urandom_range(0, 1)); c1 = 1'($urandom_range(0, 1));
    o0 = 1'($urandom_range(0, 1)); o1 = 1'($urandom_range(0, 1));
    mi = 1'($urandom_range(0, 1));
    @(negedge clk);
    resetn = rst;
    ifa.req = r; ifa.m0_cs_n = csn[0]; ifa.m1_cs_n = csn[1];
    ifa.m0_clk = c0; ifa.m1_clk = c1; ifa.m0_mosi = o0; ifa.m1_mosi = o1; ifa.spi_miso = mi;
    ifb.req = r; ifb.m0_cs_n = csn[0]; ifb.m1_cs_n = csn[1];
    ifb.m0_clk = c0; ifb.m1_clk = c1; ifb.m0_mosi = o0; ifb.m1_mosi = o1; ifb.spi_miso = mi;
    #1;
    if (chk) begin
      for (int d = 0; d < 2; d++) begin
        dn = (d == 0) ? "A" : "B";
        eg = (m_owner[d] < 0) ? 2'b00 : ((m_owner[d] == 1) ? 2'b10 : 2'b01);
        if (m_owner[d] == 0)      eb = {c0, o0, csn[0], 1'b1, mi, 1'b0};
        else if (m_owner[d] == 1) eb = {c1, o1, 1'b1, csn[1], 1'b0, mi};
        else                      eb = 6'b001100;
        if (d == 0) begin
          og = ifa.gnt; ost = {busy_a, err_a};
          ob = {ifa.spi_clk, ifa.spi_mosi, ifa.spi_cs0_n, ifa.spi_cs1_n, ifa.m0_miso, ifa.m1_miso};
        end else begin
          og = ifb.gnt; ost = {busy_b, err_b};
          ob = {ifb.spi_clk, ifb.spi_mosi, ifb.spi_cs0_n, ifb.spi_cs1_n, ifb.m0_miso, ifb.m1_miso};
        end
        check({dn, ".gnt"}, 16'(og), 16'(eg));
        check({dn, ".busy_err"}, 16'(ost),
              16'({(m_owner[d] >= 0) || (cyc < m_free[d]), m_err[d]}));
        check({dn, ".bus"}, 16'(ob), 16'(eb));
      end
    end
    model_step(0, r, csn, rst);
    model_step(1, r, csn, rst);
    cyc++;
  endtask

  int  len  [2];
  bit  tail [2];
  logic [1:0] rq, cs;

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1; m_start[d] = 0; m_free[d] = 0; m_last[d] = 1; m_err[d] = 0;
      len[d] = 0; tail[d] = 0;
    end
    resetn = 1'b0;
    cycle(2'b00, 2'b11, 1'b0, 1'b0);
    cycle(2'b00, 2'b11, 1'b0, 1'b1);
    cycle(2'b00, 2'b11, 1'b1, 1'b1);

    // Master 0 alone, clean release
    for (int i = 0; i < 8; i++) cycle(2'b01, 2'b10, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle(2'b00, 2'b11, 1'b1, 1'b1);
    // Tie after master 0 owned last; then master 1 releases with cs_n low
    for (int i = 0; i < 6; i++) cycle(2'b11, 2'b10, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) cycle(2'b10, 2'b01, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cycle(2'b00, 2'b01, 1'b1, 1'b1);
    // Master 1 mid-transfer, one reset cycle, then a tie
    for (int i = 0; i < 4; i++) cycle(2'b10, 2'b01, 1'b1, 1'b1);
    cycle(2'b10, 2'b01, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(2'b11, 2'b11, 1'b1, 1'b1);
    // Long hold to trip the timeout configuration
    for (int i = 0; i < 40; i++) cycle(2'b01, 2'b10, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cycle(2'b00, 2'b11, 1'b1, 1'b1);

    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (len[i] > 0) begin
          rq[i] = 1'b1;
          cs[i] = ($urandom_range(0, 4) == 0);
          len[i]--;
          if (len[i] == 0) tail[i] = ($urandom_range(0, 7) == 0);
        end else begin
          rq[i] = 1'b0;
          cs[i] = ~tail[i];
          tail[i] = 0;
          if ($urandom_range(0, 5) == 0) len[i] = 1 + $urandom_range(0, 39);
        end
      end
      cycle(rq, cs, ($urandom_range(0, 249) != 0), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares one physical SPI bus (spi_clk, spi_mosi, spi_miso) between two SPI masters: the SPI flash reader (master 0) and the SPI RAM controller (master 1).
- Frees output pins on the padframe; each master keeps its own chip-select pin.
- Sits in femto between the two mapped SPI controllers and the uo_out/ui_in pins.
- Uses a req/gnt handshake: a master starts a transaction only after it is granted. Ownership holds for the whole transaction, followed by an enforced idle gap.

Parameters:
- ROUND_ROBIN, 1, 1 = alternate priority on a tie; 0 = master 0 always wins a tie.
- GAP_CYCLES, 2, cycles with both chip-selects high and spi_clk low between owners (0..15).
- TIMEOUT, 0, maximum cycles one grant may be held; 0 disables the timeout (16-bit counter).

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- req  in  2  per-master bus request; held high for the whole transaction
- gnt  out  2  one-hot grant, registered
- m0_clk, m0_mosi, m0_cs_n  in  1 each  master 0 SPI outputs
- m0_miso  out  1  master 0 data in
- m1_clk, m1_mosi, m1_cs_n  in  1 each  master 1 SPI outputs
- m1_miso  out  1  master 1 data in
- spi_clk, spi_mosi  out  1 each  shared bus
- spi_miso  in  1  shared bus
- spi_cs0_n, spi_cs1_n  out  1 each  flash / RAM chip-selects
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky protocol-error flag

Behaviour:
- Reset (resetn low at a clk edge): state=IDLE, gnt=00, owner cleared, last_owner=1 (so master 0 wins the first tie), err=0.
  - Bus outputs in reset: spi_clk=0, spi_mosi=0, spi_cs0_n=1, spi_cs1_n=1, m0_miso=0, m1_miso=0.
  - Reset mid-transaction aborts the transaction immediately. The chip-selects are high from the next cycle.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If any req bit is high, choose a winner:
    - Single request: that master.
    - Both requesting and ROUND_ROBIN=1: the master that is not last_owner.
    - Both requesting and ROUND_ROBIN=0: master 0.
  - On that edge: state<=GRANT, gnt<=onehot(winner), owner<=winner, hold counter cleared.
  - Latency: req sampled high in cycle t gives gnt high in cycle t+1.
- GRANT:
  - The bus mux follows owner (a registered select, so the bus is glitch-free):
    - spi_clk=mX_clk, spi_mosi=mX_mosi, spi_csX_n=mX_cs_n.
    - The non-owner chip-select is forced to 1.
    - mX_miso=spi_miso for the owner; the non-owner's miso is 0.
  - The non-owner's clk/mosi/cs_n inputs are ignored.
  - Owner req sampled low: state<=GAP, or IDLE if GAP_CYCLES=0; gnt<=00; last_owner<=owner.
  - If the owner's cs_n is still 0 in the cycle its req is sampled low, set err.
  - If TIMEOUT>0 and the hold counter reaches TIMEOUT: revoke the grant exactly as for a req release, and set err.
  - A non-owner req arriving in GRANT waits and does not preempt.
- GAP:
  - All outputs are at their idle values.
  - Lasts exactly GAP_CYCLES cycles, counted with a 4-bit down-counter, then IDLE.
  - Requests are sampled only in IDLE.
  - Earliest next grant after owner release at cycle t: cycle t+GAP_CYCLES+2.
- Simultaneous events:
  - Owner drops req while the other master requests: the other master is granted after the gap. Under ROUND_ROBIN it also wins a tie against the previous owner re-requesting.
  - A master whose req drops in the same cycle it would be granted (IDLE sampling) is not granted.
- err clears only on reset.
- The hold counter saturates at its maximum value and does not wrap.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, GRANT=2'd1, GAP=2'd2)
  - master index constants (M_FLASH=0, M_RAM=1)
  - SPI idle-level constants
- One natural sub-module, spi_rr_pick: combinational two-way winner select from req, last_owner and ROUND_ROBIN. Unit-testable on its own.
- The FSM, counters and bus mux stay in the top module.

Test Plan:
- Reset, then req=01: gnt=01 in the cycle after req. Drive m0_clk toggling, m0_cs_n=0, m0_mosi pattern 0xA5 → spi_clk/spi_mosi mirror it, spi_cs0_n=0, spi_cs1_n=1. spi_miso drives m0_miso; m1_miso=0.
- req=11 from IDLE with ROUND_ROBIN=1 after reset → master 0 granted first. On its release, gnt=00 for 2 GAP cycles with spi_cs0_n=spi_cs1_n=1 and spi_clk=0, then gnt=10 at t+4.
- ROUND_ROBIN=0, both masters re-requesting continuously, each releasing after 8 cycles → master 0 wins every tie; master 1 is granted only while master 0 is not requesting.
- Master 1 drops req while m1_cs_n=0 → gnt=00 next cycle, spi_cs1_n forced to 1, err=1 and stays 1 until reset.
- TIMEOUT=16, master 0 holds req for 40 cycles → grant revoked when the hold counter reaches 16, err=1, GAP entered. Master 0 is granted again after the gap because its req is still high.
- resetn low for one cycle while master 1 is mid-transfer → gnt=00, both chip-selects=1, spi_clk=0 from the next cycle. State returns to IDLE; the next grant is re-arbitrated with master 0 winning a tie.
